// File: rtl/gate_truth_checker_pkg.sv
// Shared definitions for the gate truth-table checker: FSM state encoding and
// the standard 2-input truth tables (bit index = {A,B}).
package gate_truth_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_truth_checker_settle_counter.sv
// 4-bit down counter that times the settle window between driving a vector
// and sampling the gate output; zero flags the final settle cycle.
module settle_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       enable,
  input  logic [3:0] load_value,
  output logic       zero
);

  logic [3:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/gate_truth_checker.sv
// Drives all four {A,B} vectors into a 2-input gate, samples C after a settle
// window and compares against EXPECTED; reports results via busy/done/pass.
module gate_truth_checker
  import gate_truth_checker_pkg::*;
#(
  parameter logic [3:0]  EXPECTED      = TT_NAND,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       A,
  output logic       B,
  input  logic       C,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask
);

  // Counter holds SETTLE_CYCLES-1 so SETTLE exits on the cycle it reads zero.
  localparam logic [3:0] SETTLE_LOAD = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [1:0] idx;
  logic       settle_zero;

  settle_counter u_settle (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (state == ST_APPLY),
    .enable     (state == ST_SETTLE),
    .load_value (SETTLE_LOAD),
    .zero       (settle_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= 2'd0;
      A         <= 1'b0;
      B         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= 4'b0000;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          A <= 1'b0;
          B <= 1'b0;
          if (start) begin
            state     <= ST_APPLY;
            idx       <= 2'd0;
            fail_mask <= 4'b0000;
            pass      <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_APPLY: begin
          {A, B} <= idx;
          state  <= (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_zero) state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          fail_mask[idx] <= (C != EXPECTED[idx]);
          if (idx == 2'd3) begin
            state <= ST_DONE;
          end else begin
            idx   <= idx + 2'd1;
            state <= ST_APPLY;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          pass  <= ~|fail_mask;
          busy  <= 1'b0;
          A     <= 1'b0;
          B     <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: two instances (settle 2 and settle 0) around a
// truth-table-driven model gate, checked cycle by cycle against timing rules.
module tb_gate_truth_checker;
  import gate_truth_checker_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start0, start1;
  logic       a0, b0, c0, busy0, done0, pass0;
  logic       a1, b1, c1, busy1, done1, pass1;
  logic [3:0] fm0, fm1;
  logic [3:0] gate_tt;

  // Model gate under test: output looked up from its own truth table.
  assign c0 = gate_tt[{a0, b0}];
  assign c1 = gate_tt[{a1, b1}];

  gate_truth_checker #(.EXPECTED(TT_NAND), .SETTLE_CYCLES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .A(a0), .B(b0), .C(c0),
    .busy(busy0), .done(done0), .pass(pass0), .fail_mask(fm0)
  );

  gate_truth_checker #(.EXPECTED(TT_NAND), .SETTLE_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1), .C(c1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_mask(fm1)
  );

  int vectors = 0;
  int miscompares = 0;
  int sel = 0;

  logic       v_a, v_b, v_busy, v_done, v_pass;
  logic [3:0] v_fm;
  always_comb begin
    v_a = a0; v_b = b0; v_busy = busy0; v_done = done0; v_pass = pass0; v_fm = fm0;
    if (sel != 0) begin
      v_a = a1; v_b = b1; v_busy = busy1; v_done = done1; v_pass = pass1; v_fm = fm1;
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive_start(input logic v);
    if (sel == 0) start0 = v;
    else          start1 = v;
  endtask

  // One run: expected behaviour derived from per-vector period S+2, vector k
  // visible on {A,B} from cycle 1+k*(S+2), done in cycle 4*(S+2)+1.
  task automatic run_check(input int which, input logic [3:0] tt, input logic [3:0] exp_tt,
                           input int p1, input int p2, input bit hold, input string tag);
    int per, last, exp_ab;
    logic [3:0] exp_mask;
    bit exp_busy, exp_done;
    per      = ((which == 0) ? 2 : 0) + 2;
    last     = 4 * per + 1;
    exp_mask = tt ^ exp_tt;
    sel      = which;
    gate_tt  = tt;
    @(negedge clk);
    drive_start(1'b1);
    @(posedge clk); #1;
    for (int n = 0; n <= last + 2; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      exp_busy = (n <= 4 * per) || (hold && n > last);
      exp_done = (n == last);
      exp_ab   = (n >= 1 && n <= 4 * per) ? (n - 1) / per : 0;
      chk({tag, $sformatf(" busy@%0d", n)}, {7'd0, v_busy}, {7'd0, exp_busy});
      chk({tag, $sformatf(" done@%0d", n)}, {7'd0, v_done}, {7'd0, exp_done});
      chk({tag, $sformatf(" ab@%0d", n)}, {6'd0, v_a, v_b}, 8'(exp_ab));
      if (n >= last && !(hold && n > last)) begin
        chk({tag, $sformatf(" fail_mask@%0d", n)}, {4'd0, v_fm}, {4'd0, exp_mask});
        chk({tag, $sformatf(" pass@%0d", n)}, {7'd0, v_pass}, {7'd0, exp_mask == 4'd0});
      end else begin
        chk({tag, $sformatf(" pass_low@%0d", n)}, {7'd0, v_pass}, 8'd0);
      end
      @(negedge clk);
      drive_start(hold || (n + 1 == p1) || (n + 1 == p2));
    end
  endtask

  initial begin
    bit got_done;
    int which;
    logic [3:0] tt;
    rst_n   = 1'b0;
    start0  = 1'b0;
    start1  = 1'b0;
    gate_tt = TT_NAND;
    repeat (2) @(posedge clk);
    #1;
    chk("reset dut0", {a0, b0, busy0, done0, pass0, 3'd0} | {4'd0, fm0}, 8'd0);
    chk("reset dut1", {a1, b1, busy1, done1, pass1, 3'd0} | {4'd0, fm1}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_check(0, TT_NAND, TT_NAND, -1, -1, 1'b0, "nand_s2");
    run_check(0, TT_AND,  TT_NAND, -1, -1, 1'b0, "and_s2");
    run_check(0, TT_XOR,  TT_NAND, -1, -1, 1'b0, "xor_s2");
    run_check(1, TT_NAND, TT_NAND, -1, -1, 1'b0, "nand_s0");
    run_check(0, TT_NAND, TT_NAND, 3, 10, 1'b0, "repulse");

    for (int r = 0; r < 6; r++) begin
      which = int'($urandom_range(0, 1));
      tt    = 4'($urandom_range(0, 15));
      run_check(which, tt, TT_NAND, -1, -1, 1'b0, $sformatf("rand%0d_tt%b", r, tt));
    end

    // Held start: re-accepted in the first IDLE cycle, then drained.
    run_check(1, TT_OR, TT_NAND, -1, -1, 1'b1, "hold_s0");
    drive_start(1'b0);
    got_done = 1'b0;
    for (int i = 0; i < 60 && !got_done; i++) begin
      @(posedge clk); #1;
      if (done1) got_done = 1'b1;
    end
    chk("hold rerun done", {7'd0, got_done}, 8'd1);
    chk("hold rerun mask", {4'd0, fm1}, {4'd0, TT_OR ^ TT_NAND});

    // Reset mid-run discards the partial result and suppresses done.
    sel     = 0;
    gate_tt = TT_AND;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midrun partial mask", {4'd0, fm0}, 8'b0000_0001);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrun reset outputs", {a0, b0, busy0, done0, pass0, 3'd0} | {4'd0, fm0}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("midrun no done %0d", i), {6'd0, busy0, done0}, 8'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_check(0, TT_NAND, TT_NAND, -1, -1, 1'b0, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
